fp_round_pipe: RTL and testbench

Parametrised, pipelined successor to the FP adder rounding stage. Accepts a normalized significand with round/sticky bits, sign, pre-round exponent and rounding mode, and applies the selected rounding mode. Produces the rounded significand, the final exponent, and IEEE inexact/overflow flags through a two-stage valid/ready pipeline with full backpressure. Sits between the normalizer and the special-case/pack stage of the FP adder, and is reusable by the multiplier datapath.

---
 rtl/fp_pkg.sv | 13 +
 rtl/fp_round_decide.sv | 26 ++
 rtl/fp_round_pipe.sv | 107 ++++++++++
 tb/tb_fp_round_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP rounding widths and rounding-mode encodings
package fp_pkg;

  localparam int WEXP_DEF = 8;
  localparam int WSIG_DEF = 23;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RZ  = 3'b001;
  localparam logic [2:0] RM_RP  = 3'b010;
  localparam logic [2:0] RM_RM  = 3'b011;
  localparam logic [2:0] RM_RNA = 3'b100;

endpackage

// File: rtl/fp_round_decide.sv
// rtl/fp_round_decide.sv - combinational add-one decision for a rounding mode
module fp_round_decide
  import fp_pkg::*;
(
  input  logic [2:0] roundmode,
  input  logic       sign,
  input  logic       round,
  input  logic       sticky,
  input  logic       lsb,
  output logic       addone
);

  always_comb begin
    addone = 1'b0;
    case (roundmode)
      RM_RNE:  addone = round & (sticky | lsb);
      RM_RZ:   addone = 1'b0;
      RM_RP:   addone = ~sign & (round | sticky);
      RM_RM:   addone = sign & (round | sticky);
      RM_RNA:  addone = round;
      // unassigned encodings truncate like RZ
      default: addone = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - two-stage valid/ready rounding stage for the FP datapath
module fp_round_pipe
  import fp_pkg::*;
#(
  parameter int WEXP = WEXP_DEF,
  parameter int WSIG = WSIG_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WSIG-1:0] normsum,
  input  logic            round,
  input  logic            sticky,
  input  logic            finalsign,
  input  logic [WEXP-1:0] overexp,
  input  logic [2:0]      roundmode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WSIG-1:0] roundsum,
  output logic [WEXP:0]   exp,
  output logic            roundshift,
  output logic            sign_out,
  output logic            inexact,
  output logic            overflow
);

  localparam logic [WEXP:0] EXP_MAX = {1'b0, {WEXP{1'b1}}};

  logic v1, v2, adv1, adv2;
  logic addone_d;

  logic            s1_addone;
  logic [WSIG:0]   s1_sum;
  logic [WSIG-1:0] s1_norm;
  logic [WEXP-1:0] s1_exp;
  logic            s1_sign;
  logic            s1_inexact;

  logic            roundshift_d;
  logic [WSIG-1:0] roundsum_d;
  logic [WEXP:0]   exp_d;

  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1 | reset;
  assign out_valid = v2;

  fp_round_decide u_decide (
    .roundmode (roundmode),
    .sign      (finalsign),
    .round     (round),
    .sticky    (sticky),
    .lsb       (normsum[0]),
    .addone    (addone_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1         <= 1'b0;
      s1_addone  <= 1'b0;
      s1_sum     <= '0;
      s1_norm    <= '0;
      s1_exp     <= '0;
      s1_sign    <= 1'b0;
      s1_inexact <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_addone  <= addone_d;
        s1_sum     <= {1'b0, normsum} + (WSIG+1)'(1);
        s1_norm    <= normsum;
        s1_exp     <= overexp;
        s1_sign    <= finalsign;
        s1_inexact <= round | sticky;
      end
    end
  end

  // a carry out leaves the low WSIG sum bits all zero, so no extra masking is needed
  assign roundshift_d = s1_sum[WSIG] & s1_addone;
  assign roundsum_d   = s1_addone ? s1_sum[WSIG-1:0] : s1_norm;
  assign exp_d        = {1'b0, s1_exp} + (roundshift_d ? (WEXP+1)'(2) : (WEXP+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      v2         <= 1'b0;
      roundsum   <= '0;
      exp        <= '0;
      roundshift <= 1'b0;
      sign_out   <= 1'b0;
      inexact    <= 1'b0;
      overflow   <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        roundsum   <= roundsum_d;
        exp        <= exp_d;
        roundshift <= roundshift_d;
        sign_out   <= s1_sign;
        inexact    <= s1_inexact;
        overflow   <= exp_d >= EXP_MAX;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb/tb_fp_round_pipe.sv - self-checking bench for fp_round_pipe
module tb_fp_round_pipe;
  import fp_pkg::*;

  typedef logic [35:0] res_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, round, sticky, finalsign;
  logic [22:0] normsum;
  logic [7:0]  overexp;
  logic [2:0]  roundmode;
  logic        out_valid, out_ready, roundshift, sign_out, inexact, overflow;
  logic [22:0] roundsum;
  logic [8:0]  exp;
  res_t        got;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_round_pipe #(.WEXP(8), .WSIG(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .normsum(normsum), .round(round), .sticky(sticky), .finalsign(finalsign),
    .overexp(overexp), .roundmode(roundmode), .out_valid(out_valid),
    .out_ready(out_ready), .roundsum(roundsum), .exp(exp), .roundshift(roundshift),
    .sign_out(sign_out), .inexact(inexact), .overflow(overflow)
  );

  assign got = {roundsum, exp, roundshift, sign_out, inexact, overflow};

  // Reference: classify the discarded fraction against one half, then round the integer value.
  function automatic res_t model(input logic [22:0] ns, input logic r, input logic s,
                                 input logic sg, input logic [7:0] oe, input logic [2:0] m);
    int     frac;
    bit     up, sh;
    longint total;
    int     e;
    logic [22:0] rs;
    logic [8:0]  ev;
    frac = r ? (s ? 3 : 2) : (s ? 1 : 0);
    case (m)
      3'b000:  up = (frac == 3) || (frac == 2 && ns[0]);
      3'b010:  up = !sg && frac != 0;
      3'b011:  up = sg && frac != 0;
      3'b100:  up = frac >= 2;
      default: up = 1'b0;
    endcase
    total = longint'(ns) + (up ? 1 : 0);
    sh = total >= (longint'(1) << 23);
    rs = sh ? 23'd0 : total[22:0];
    e  = int'(oe) + 1 + (sh ? 1 : 0);
    ev = e[8:0];
    return {rs, ev, sh, sg, (r | s), (e >= 255)};
  endfunction

  task automatic set_in(input logic [22:0] ns, input logic r, input logic s,
                        input logic sg, input logic [7:0] oe, input logic [2:0] m);
    normsum = ns; round = r; sticky = s; finalsign = sg; overexp = oe; roundmode = m;
  endtask

  task automatic run_one(input string tag, input logic [22:0] ns, input logic r, input logic s,
                         input logic sg, input logic [7:0] oe, input logic [2:0] m,
                         output res_t res);
    int cnt;
    @(negedge clk);
    set_in(ns, r, s, sg, oe, m);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 10);
    checks++;
    if (cnt !== 2 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles valid=%b, expected 2 cycles valid=1", tag, cnt, out_valid);
    end
    res = got;
    checks++;
    if (got !== model(ns, r, s, sg, oe, m)) begin
      failures++;
      $display("FAIL %s model: got %h, expected %h", tag, got, model(ns, r, s, sg, oe, m));
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_in('0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || got !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: valid=%b out=%h in_ready=%b, expected 0/0/1", out_valid, got, in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_rne;
    res_t r;
    run_one("rne_even", 23'h000002, 1'b1, 1'b0, 1'b0, 8'h40, RM_RNE, r);
    checks++;
    if (r[35:13] !== 23'h000002 || r[12:4] !== 9'h041 || r[1] !== 1'b1) begin
      failures++;
      $display("FAIL rne_even: got rs=%h exp=%h inx=%b, expected 000002/041/1", r[35:13], r[12:4], r[1]);
    end
    run_one("rne_odd", 23'h000003, 1'b1, 1'b0, 1'b0, 8'h40, RM_RNE, r);
    checks++;
    if (r[35:13] !== 23'h000004 || r[12:4] !== 9'h041) begin
      failures++;
      $display("FAIL rne_odd: got rs=%h exp=%h, expected 000004/041", r[35:13], r[12:4]);
    end
  endtask

  task automatic test_carry;
    res_t r;
    run_one("carry", 23'h7FFFFF, 1'b0, 1'b1, 1'b0, 8'h7C, RM_RP, r);
    checks++;
    if (r[35:13] !== 23'h0 || r[3] !== 1'b1 || r[12:4] !== 9'h07E) begin
      failures++;
      $display("FAIL carry: got rs=%h sh=%b exp=%h, expected 000000/1/07E", r[35:13], r[3], r[12:4]);
    end
  endtask

  task automatic test_overflow;
    res_t r;
    run_one("ovf_carry", 23'h7FFFFF, 1'b0, 1'b1, 1'b0, 8'hFD, RM_RP, r);
    checks++;
    if (r[12:4] !== 9'h0FF || r[0] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_carry: got exp=%h ovf=%b, expected 0FF/1", r[12:4], r[0]);
    end
    run_one("ovf_nocarry", 23'h7FFFFF, 1'b0, 1'b1, 1'b0, 8'hFD, RM_RZ, r);
    checks++;
    if (r[12:4] !== 9'h0FE || r[0] !== 1'b0 || r[3] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_nocarry: got exp=%h ovf=%b sh=%b, expected 0FE/0/0", r[12:4], r[0], r[3]);
    end
  endtask

  task automatic test_modes;
    logic [2:0]  modes [5];
    logic [22:0] want  [5];
    res_t r;
    modes = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
    want  = '{23'h123456, 23'h123456, 23'h123457, 23'h123457, 23'h123456};
    for (int i = 0; i < 5; i++) begin
      run_one("modes", 23'h123456, 1'b1, 1'b1, 1'b1, 8'h55, modes[i], r);
      checks++;
      if (r[35:13] !== want[i] || r[2] !== 1'b1) begin
        failures++;
        $display("FAIL mode_%b: got rs=%h sign=%b, expected %h/1", modes[i], r[35:13], r[2], want[i]);
      end
    end
  endtask

  task automatic test_random;
    res_t r;
    logic [22:0] ns;
    for (int i = 0; i < 16; i++) begin
      ns = (i % 4 == 0) ? 23'h7FFFFF : 23'($urandom);
      run_one("random", ns, 1'($urandom), 1'($urandom), 1'($urandom),
              8'($urandom), 3'($urandom_range(0, 7)), r);
    end
  endtask

  task automatic test_back_to_back;
    res_t q[$];
    res_t held;
    int   sent = 0, recv = 0, cyc = 0;
    bit   stalled = 0, acc = 0;
    in_valid = 1'b0;
    while ((sent < 8 || recv < 8) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < 8) begin
        set_in(23'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               8'($urandom), 3'($urandom_range(0, 7)));
        in_valid = 1'b1;
      end
      #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          failures++;
          $display("FAIL stall_hold: got valid=%b out=%h, expected 1/%h", out_valid, got, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL bp_order: got unexpected output %h, expected none", got);
        end else begin
          if (got !== q[0]) begin
            failures++;
            $display("FAIL bp_order: got %h, expected %h", got, q[0]);
          end
          void'(q.pop_front());
        end
        recv++;
      end
      stalled = out_valid && !out_ready;
      held = got;
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(model(normsum, round, sticky, finalsign, overexp, roundmode));
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sent != 8 || recv != 8 || q.size() != 0) begin
      failures++;
      $display("FAIL bp_count: got sent=%0d recv=%0d left=%0d, expected 8/8/0", sent, recv, q.size());
    end
  endtask

  task automatic test_reset_midstream;
    res_t r;
    @(negedge clk);
    out_ready = 1'b0;
    set_in(23'h111111, 1'b1, 1'b1, 1'b0, 8'h10, RM_RP);
    in_valid = 1'b1;
    @(negedge clk);
    set_in(23'h222222, 1'b1, 1'b1, 1'b0, 8'h20, RM_RP);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL pipe_full: got valid=%b in_ready=%b, expected 1/0", out_valid, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp !== 9'h0 || roundsum !== 23'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset: got valid=%b exp=%h rs=%h in_ready=%b, expected 0/000/000000/1",
               out_valid, exp, roundsum, in_ready);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flush: got valid=%b, expected 0", out_valid);
    end
    run_one("after_reset", 23'h3ABCDE, 1'b1, 1'b0, 1'b1, 8'h80, RM_RNA, r);
  endtask

  initial begin
    test_reset;
    test_rne;
    test_carry;
    test_overflow;
    test_modes;
    test_random;
    test_back_to_back;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
